// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: op encodings, FSM states and the flag bundle.
package alu_pkg;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_OR   = 3'b011;
   localparam logic [2:0] OP_NOT  = 3'b100;
   localparam logic [2:0] OP_XOR  = 3'b101;
   localparam logic [2:0] OP_MUL  = 3'b110;
   localparam logic [2:0] OP_RSVD = 3'b111;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      MUL_BUSY = 2'd1,
      DONE     = 2'd2
   } alu_state_t;

   typedef struct packed {
      logic zero;
      logic carry;
      logic ovf;
      logic err;
   } alu_flags_t;

   function automatic logic is_mul(input logic [2:0] op);
      return op == OP_MUL;
   endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle between the issuing controller (master) and the ALU (slave).
interface alu_seq_if #(
   parameter int WIDTH = 8
);
   localparam int RES_W = 2 * WIDTH;

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [2:0]       op;
   logic             out_valid;
   logic             out_ready;
   logic [RES_W-1:0] result;
   logic             flag_zero;
   logic             flag_carry;
   logic             flag_ovf;
   logic             flag_err;

   modport master (
      output in_valid, a, b, op, out_ready,
      input  in_ready, out_valid, result, flag_zero, flag_carry, flag_ovf, flag_err
   );

   modport slave (
      input  in_valid, a, b, op, out_ready,
      output in_ready, out_valid, result, flag_zero, flag_carry, flag_ovf, flag_err
   );

endinterface

// File: rtl/alu_mul_seq.sv
// Shift-add unsigned multiplier: one partial product per cycle, WIDTH cycles after start.
module alu_mul_seq #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int RES_W = 2 * WIDTH;
   localparam int CNT_W = $clog2(WIDTH + 1);

   logic [RES_W-1:0] mcand;
   logic [RES_W-1:0] acc;
   logic [WIDTH-1:0] mplier;
   logic [CNT_W-1:0] count;

   // done is a single-cycle pulse raised once the last partial product has been added
   always_ff @(posedge clk) begin
      if (!rst) begin
         mcand  <= '0;
         acc    <= '0;
         mplier <= '0;
         count  <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         if (busy) begin
            if (mplier[0]) begin
               acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count - CNT_W'(1);
            if (count == CNT_W'(1)) begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end else if (start) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            count  <= CNT_W'(WIDTH);
            busy   <= 1'b1;
         end
      end
   end

   assign product = acc;

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes, status flags and a multi-cycle multiply.
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input logic      clk,
   input logic      rst,
   alu_seq_if.slave bus
);

   localparam int RES_W = 2 * WIDTH;

   alu_state_t       state;
   alu_state_t       state_nxt;
   logic             accept;
   logic             load_single;
   logic             load_mul;
   logic             mul_start;
   logic             mul_busy;
   logic             mul_done;
   logic [RES_W-1:0] product;
   logic [RES_W-1:0] res_c;
   logic [RES_W-1:0] res_q;
   alu_flags_t       flg_c;
   alu_flags_t       flg_mul;
   alu_flags_t       flg_q;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;

   // in_ready looks straight through to out_ready so a consumed result can be replaced on the same edge
   assign bus.in_ready = ((state == IDLE) && !mul_busy) || ((state == DONE) && bus.out_ready);
   assign accept       = bus.in_valid && bus.in_ready;
   assign mul_start    = accept && is_mul(bus.op);
   assign load_single  = accept && !is_mul(bus.op);
   assign load_mul     = (state == MUL_BUSY) && mul_done;

   alu_mul_seq #(
      .WIDTH(WIDTH)
   ) u_mul (
      .clk    (clk),
      .rst    (rst),
      .start  (mul_start),
      .a      (bus.a),
      .b      (bus.b),
      .busy   (mul_busy),
      .done   (mul_done),
      .product(product)
   );

   // Single-cycle datapath; the extra bit of sum/diff is the carry/borrow
   always_comb begin
      sum   = {1'b0, bus.a} + {1'b0, bus.b};
      diff  = {1'b0, bus.a} - {1'b0, bus.b};
      res_c = '0;
      flg_c = '0;
      case (bus.op)
         OP_ADD: begin
            res_c       = {{(WIDTH-1){1'b0}}, sum};
            flg_c.carry = sum[WIDTH];
            flg_c.ovf   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
         end
         OP_SUB: begin
            res_c       = {{WIDTH{1'b0}}, diff[WIDTH-1:0]};
            flg_c.carry = diff[WIDTH];
            flg_c.ovf   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
         end
         OP_AND: res_c = {{WIDTH{1'b0}}, bus.a & bus.b};
         OP_OR:  res_c = {{WIDTH{1'b0}}, bus.a | bus.b};
         OP_XOR: res_c = {{WIDTH{1'b0}}, bus.a ^ bus.b};
         OP_NOT: begin
            if (bus.a != '0) begin
               res_c = {{WIDTH{1'b0}}, ~bus.a};
            end else if (bus.b != '0) begin
               res_c = {{WIDTH{1'b0}}, ~bus.b};
            end
         end
         OP_RSVD: flg_c.err = 1'b1;
         default: res_c = '0;
      endcase
      flg_c.zero = (res_c == '0);
   end

   always_comb begin
      flg_mul       = '0;
      flg_mul.zero  = (product == '0);
      flg_mul.ovf   = (product[RES_W-1:WIDTH] != '0);
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = is_mul(bus.op) ? MUL_BUSY : DONE;
            end
         end
         MUL_BUSY: begin
            if (mul_done) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               if (accept) begin
                  state_nxt = is_mul(bus.op) ? MUL_BUSY : DONE;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Result and flags only move on entry to DONE, so they stay frozen under backpressure
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         res_q <= '0;
         flg_q <= '0;
      end else begin
         state <= state_nxt;
         if (load_single) begin
            res_q <= res_c;
            flg_q <= flg_c;
         end else if (load_mul) begin
            res_q <= product;
            flg_q <= flg_mul;
         end
      end
   end

   assign bus.out_valid  = (state == DONE);
   assign bus.result     = res_q;
   assign bus.flag_zero  = flg_q.zero;
   assign bus.flag_carry = flg_q.carry;
   assign bus.flag_ovf   = flg_q.ovf;
   assign bus.flag_err   = flg_q.err;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with an arithmetic reference model checked on every valid output cycle.
module tb_alu_seq;
   import alu_pkg::*;

   localparam int W  = 8;
   localparam int RW = 2 * W;

   typedef struct {
      logic [RW-1:0] res;
      logic          z;
      logic          c;
      logic          o;
      logic          e;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   failures = 0;
   bit   rstAtEdge = 1'b1;
   exp_t expq[$];

   alu_seq_if #(.WIDTH(W)) bus ();

   alu_seq #(.WIDTH(W)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) rstAtEdge = rst;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   // Results computed from plain integer arithmetic and two's-complement ranges
   function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t   e;
      longint m, ua, ub, sa, sb, r, s;
      m  = longint'(1) << W;
      ua = longint'(a);
      ub = longint'(b);
      sa = (ua >= m / 2) ? ua - m : ua;
      sb = (ub >= m / 2) ? ub - m : ub;
      r  = 0;
      e.c = 1'b0;
      e.o = 1'b0;
      e.e = 1'b0;
      case (op)
         OP_ADD: begin
            r   = ua + ub;
            s   = sa + sb;
            e.c = (r >= m);
            e.o = (s >= m / 2) || (s < -(m / 2));
         end
         OP_SUB: begin
            r   = (ua - ub + m) % m;
            s   = sa - sb;
            e.c = (ua < ub);
            e.o = (s >= m / 2) || (s < -(m / 2));
         end
         OP_AND: r = ua & ub;
         OP_OR:  r = ua | ub;
         OP_XOR: r = ua ^ ub;
         OP_NOT: r = (ua != 0) ? (m - 1 - ua) : ((ub != 0) ? (m - 1 - ub) : 0);
         OP_MUL: begin
            r   = ua * ub;
            e.o = (r >= m);
         end
         default: begin
            r   = 0;
            e.e = 1'b1;
         end
      endcase
      e.res = r[RW-1:0];
      e.z   = (r == 0);
      return e;
   endfunction

   // Compare process: reset state after a reset edge, model result whenever out_valid is high
   always @(negedge clk) begin
      if (!rstAtEdge) begin
         checkOutput("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
         checkOutput("rst_result", {16'd0, bus.result}, 32'd0);
         checkOutput("rst_flags", {28'd0, bus.flag_zero, bus.flag_carry, bus.flag_ovf, bus.flag_err}, 32'd0);
      end
      if (!rst) begin
         expq.delete();
      end else begin
         if (bus.out_valid === 1'b1) begin
            if (expq.size() == 0) begin
               checkOutput("spurious_out_valid", {31'd0, bus.out_valid}, 32'd0);
            end else begin
               checkOutput("model_result", {16'd0, bus.result}, {16'd0, expq[0].res});
               checkOutput("model_flags",
                           {28'd0, bus.flag_zero, bus.flag_carry, bus.flag_ovf, bus.flag_err},
                           {28'd0, expq[0].z, expq[0].c, expq[0].o, expq[0].e});
               if (bus.out_ready === 1'b1) begin
                  void'(expq.pop_front());
               end
            end
         end
         if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
            expq.push_back(model(bus.op, bus.a, bus.b));
         end
      end
   end

   task automatic applyStimulus(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic rdy, output int waits);
      @(posedge clk);
      #2;
      bus.in_valid  = 1'b1;
      bus.op        = op;
      bus.a         = a;
      bus.b         = b;
      bus.out_ready = rdy;
      waits = 0;
      @(negedge clk);
      while (bus.in_ready !== 1'b1 && waits < 40) begin
         @(negedge clk);
         waits++;
      end
      if (bus.in_ready !== 1'b1) begin
         checkOutput("accept_timeout", {31'd0, bus.in_ready}, 32'd1);
      end
      @(posedge clk);
      #2;
      bus.in_valid = 1'b0;
   endtask

   task automatic waitValid(input int maxc, input logic busyCheck, output int cycles);
      cycles = 0;
      @(negedge clk);
      while (bus.out_valid !== 1'b1 && cycles < maxc) begin
         if (busyCheck) begin
            checkOutput("mul_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
         end
         @(negedge clk);
         cycles++;
      end
      if (bus.out_valid !== 1'b1) begin
         checkOutput("out_valid_timeout", {31'd0, bus.out_valid}, 32'd1);
      end
   endtask

   task automatic doOp(input string name, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int expLat, input logic [RW-1:0] expRes, input logic [3:0] expZcoe);
      int w, c;
      applyStimulus(op, a, b, 1'b1, w);
      waitValid(20, op == OP_MUL, c);
      checkOutput({name, "_latency"}, c, expLat);
      checkOutput({name, "_result"}, {16'd0, bus.result}, {16'd0, expRes});
      checkOutput({name, "_flags"}, {28'd0, bus.flag_zero, bus.flag_carry, bus.flag_ovf, bus.flag_err},
                  {28'd0, expZcoe});
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] simulation did not finish");
   end

   initial begin
      int w, c;
      bus.in_valid  = 1'b1;
      bus.op        = OP_ADD;
      bus.a         = 8'd1;
      bus.b         = 8'd1;
      bus.out_ready = 1'b1;

      // Reset held two edges while an ADD is offered
      repeat (2) @(posedge clk);
      #2;
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      checkOutput("rel_in_ready", {31'd0, bus.in_ready}, 32'd1);
      checkOutput("rel_out_valid", {31'd0, bus.out_valid}, 32'd0);

      // Flags as {zero, carry, ovf, err}
      doOp("add_carry", OP_ADD, 8'd200, 8'd100, 0, 16'h012C, 4'b0100);
      doOp("sub_borrow", OP_SUB, 8'd5, 8'd7, 0, 16'h00FE, 4'b0100);
      doOp("add_ovf", OP_ADD, 8'd100, 8'd100, 0, 16'h00C8, 4'b0010);
      doOp("add_wrap", OP_ADD, 8'd255, 8'd1, 0, 16'h0100, 4'b0100);
      doOp("sub_ovf", OP_SUB, 8'h80, 8'h01, 0, 16'h007F, 4'b0010);
      doOp("mul_max", OP_MUL, 8'd255, 8'd255, 9, 16'hFE01, 4'b0010);
      doOp("mul_zero", OP_MUL, 8'd0, 8'd37, 9, 16'h0000, 4'b1000);

      // Backpressure: AND result must hold while out_ready is low
      applyStimulus(OP_AND, 8'hF0, 8'h3C, 1'b0, w);
      waitValid(5, 1'b0, c);
      checkOutput("and_latency", c, 0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("hold_result", {16'd0, bus.result}, 32'h30);
         checkOutput("hold_valid", {31'd0, bus.out_valid}, 32'd1);
         checkOutput("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
      end
      applyStimulus(OP_XOR, 8'hFF, 8'h0F, 1'b1, w);
      checkOutput("b2b_no_wait", w, 0);
      waitValid(5, 1'b0, c);
      checkOutput("b2b_latency", c, 0);
      checkOutput("b2b_result", {16'd0, bus.result}, 32'hF0);

      doOp("not_b", OP_NOT, 8'h00, 8'h0F, 0, 16'h00F0, 4'b0000);
      doOp("not_a", OP_NOT, 8'h0F, 8'h33, 0, 16'h00F0, 4'b0000);
      doOp("not_zero", OP_NOT, 8'h00, 8'h00, 0, 16'h0000, 4'b1000);
      doOp("rsvd", OP_RSVD, 8'h03, 8'h04, 0, 16'h0000, 4'b1001);

      // Reset asserted during the fourth multiply cycle
      applyStimulus(OP_MUL, 8'd13, 8'd11, 1'b1, w);
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("mid_mul_busy", {31'd0, bus.in_ready}, 32'd0);
      @(posedge clk);
      #2;
      rst = 1'b1;
      @(negedge clk);
      checkOutput("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         checkOutput("no_residue", {31'd0, bus.out_valid}, 32'd0);
      end
      doOp("post_rst_add", OP_ADD, 8'd1, 8'd1, 0, 16'h0002, 4'b0000);

      @(negedge clk);
      checkOutput("queue_drained", expq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
